pipeline_stall_ctrl: RTL and testbench
======================================

# pipeline_stall_ctrl

Central stall/flush sequencer for the 5-stage MIPS pipeline. Merges ID-stage hazard requests (jump/branch-operand stall, load-use stall) with I-cache/D-cache miss stalls and taken-branch/jump redirects. Drives the enable, bubble and flush controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB. Tracks stall episodes for a deadlock watchdog and saturating performance counters.

## Interface
- STALL_MAX, 64: consecutive hazard-stall cycles before the watchdog trips.
- CNT_W, 32: width of each performance counter.
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset; one clock, synchronous, active-low.
- stallJ  in  1  branch/jump operand-not-ready stall from the jump forwarding unit.
- load_use  in  1  ID/EX load-use hazard stall.
- ICache_stall  in  1  I-cache miss pending.
- DCache_stall  in  1  D-cache miss pending.
- redirect  in  1  single-cycle pulse: taken branch or jump resolved in ID.
- PC_en  out  1  PC write enable.
- IFID_en  out  1  IF/ID write enable.
- IFID_flush  out  1  load NOP into IF/ID.
- IDEX_en  out  1  ID/EX write enable.
- IDEX_bubble  out  1  load NOP (control bits zero) into ID/EX.
- EXMEM_en, MEMWB_en  out  1 each  EX/MEM, MEM/WB write enables.
- hazard_timeout  out  1  sticky watchdog error.
- cnt_stall  out  CNT_W  total hazard-stall cycles.
- cnt_freeze  out  CNT_W  total memory-freeze cycles.
- cnt_flush  out  CNT_W  total IF/ID flushes issued.

## Operation
- Priority, evaluated every cycle:
  - freeze = ICache_stall | DCache_stall
  - hazard = stallJ | load_use
  - flush = redirect | redirect_pend
- Freeze: all five enables 0; IFID_flush=0, IDEX_bubble=0.
- Hazard without freeze:
  - PC_en=0, IFID_en=0, IDEX_en=1, IDEX_bubble=1, EXMEM_en=MEMWB_en=1.
  - redirect in the same cycle is ignored, because a branch cannot resolve while its operands stall.
- Flush without freeze or hazard: all enables 1, IFID_flush=1.
- Otherwise: all enables 1, no bubble, no flush.
- redirect_pend register:
  - Set when redirect=1 during freeze.
  - Cleared on the first cycle IFID_flush=1.
  - Reset 0.
- FSM states, with transitions decided each cycle from the inputs:
  - RUN → FREEZE on freeze.
  - RUN → HAZ on hazard without freeze.
  - HAZ → FREEZE on freeze.
  - HAZ → RUN when hazard drops.
  - FREEZE → HAZ if hazard and not freeze.
  - FREEZE → RUN if neither.
  - Any → ERR when the watchdog trips. ERR is absorbing until reset.
  - In ERR, pipeline controls behave as in RUN (priority logic unchanged); only hazard_timeout=1.
- Watchdog:
  - haz_run counter increments each cycle in HAZ with hazard still asserted.
  - Clears on any cycle without hazard. Holds, not clears, during freeze.
  - Reaching STALL_MAX sets hazard_timeout.
- Counters:
  - cnt_stall +1 per hazard-stall cycle.
  - cnt_freeze +1 per freeze cycle.
  - cnt_flush +1 per cycle with IFID_flush=1.
  - All saturate at 2^CNT_W−1; no wrap.

## Timing
- Pipeline control outputs are combinational from current inputs plus redirect_pend. Zero-cycle latency is required so the same-cycle register enables are correct.
- State, redirect_pend, watchdog and counters update on the rising clk edge.
- Reset values (rst_n=0 at an edge): state RUN, redirect_pend 0, haz_run 0, hazard_timeout 0, all counters 0.
- Control outputs during reset:
  - Follow the priority logic.
  - redirect_pend is forced 0, so with idle inputs PC_en=1 and the other enables are 1.
- Reset mid-freeze discards a pending redirect.
- Simultaneous freeze, hazard and redirect: freeze wins; redirect latches into redirect_pend; cnt_freeze increments; cnt_stall does not.
- A flush issued from redirect_pend occurs on the first non-freeze, non-hazard cycle.

## Structure
- Package pipe_ctrl_pkg holds:
  - State enum {RUN, HAZ, FREEZE, ERR}.
  - Default STALL_MAX and CNT_W constants.
- Sub-module sat_counter (parameter W; ports clk, rst_n, inc, q) is instantiated three times for the performance counters.

## Test plan
- Idle, then a one-cycle load_use → that cycle PC_en=0, IFID_en=0, IDEX_bubble=1; next cycle all enables 1; cnt_stall=1.
- ICache_stall for 5 cycles with redirect pulsed in cycle 2 → all enables 0 for 5 cycles; IFID_flush=1 in cycle 6 only; cnt_freeze=5, cnt_flush=1.
- stallJ held for STALL_MAX=4 cycles → hazard_timeout rises after the 4th edge and stays 1 after stallJ drops, until rst_n=0.
- stallJ and DCache_stall together for 3 cycles → freeze controls; cnt_stall unchanged; haz_run frozen.
- Force cnt_flush near saturation (CNT_W=4, 16 redirects) → counter reads 15, holds at 15.
- rst_n=0 for one cycle during freeze with redirect_pend=1 → after release, no flush issued; all counters 0.

Source files
------------

// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared types and default sizing for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HAZ    = 2'd1,
    FREEZE = 2'd2,
    ERR    = 2'd3
  } state_e;

  localparam int unsigned STALL_MAX_DEF = 64;
  localparam int unsigned CNT_W_DEF     = 32;

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Stall requests into the sequencer and per-stage register controls out of it.
interface pipeline_stall_ctrl_if;

  logic stallJ;
  logic load_use;
  logic ICache_stall;
  logic DCache_stall;
  logic redirect;

  logic PC_en;
  logic IFID_en;
  logic IFID_flush;
  logic IDEX_en;
  logic IDEX_bubble;
  logic EXMEM_en;
  logic MEMWB_en;

  // Pipeline side: raises requests, consumes register controls.
  modport master (
    output stallJ, load_use, ICache_stall, DCache_stall, redirect,
    input  PC_en, IFID_en, IFID_flush, IDEX_en, IDEX_bubble, EXMEM_en, MEMWB_en
  );

  // Sequencer side.
  modport slave (
    input  stallJ, load_use, ICache_stall, DCache_stall, redirect,
    output PC_en, IFID_en, IFID_flush, IDEX_en, IDEX_bubble, EXMEM_en, MEMWB_en
  );

endinterface

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q, q_d;

  // Next count: advance on inc, stick at all-ones.
  always_comb begin
    q_d = q_q;
    if (inc && (q_q != '1)) q_d = q_q + 1'b1;
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush sequencer: merges hazard, cache-miss and redirect
// requests into PC / pipeline-register controls, with watchdog and counters.
module pipeline_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned STALL_MAX = STALL_MAX_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pipeline_stall_ctrl_if.slave ctrl,
  output logic                 hazard_timeout,
  output logic [CNT_W-1:0]     cnt_stall,
  output logic [CNT_W-1:0]     cnt_freeze,
  output logic [CNT_W-1:0]     cnt_flush
);

  localparam int unsigned HR_W = $clog2(STALL_MAX + 1);
  localparam logic [HR_W-1:0] HR_MAX = HR_W'(STALL_MAX);

  state_e          state_q, state_d;
  logic            redirect_pend_q, redirect_pend_d;
  logic [HR_W-1:0] haz_run_q, haz_run_d;

  logic freeze, hazard, flush, pend_eff;
  logic haz_stall, trip;

  // Pending redirect is ignored while reset is held so reset-cycle controls stay clean.
  assign pend_eff  = redirect_pend_q & rst_n;
  assign freeze    = ctrl.ICache_stall | ctrl.DCache_stall;
  assign hazard    = ctrl.stallJ | ctrl.load_use;
  assign flush     = ctrl.redirect | pend_eff;
  assign haz_stall = hazard & ~freeze;
  assign trip      = haz_stall & (haz_run_q >= HR_MAX - 1'b1);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  // Next-state: ERR absorbs; otherwise the mode follows this cycle's requests.
  always_comb begin
    state_d = state_q;
    if (state_q == ERR || trip) state_d = ERR;
    else if (freeze)            state_d = FREEZE;
    else if (hazard)            state_d = HAZ;
    else                        state_d = RUN;
  end

  // Outputs: priority freeze > hazard > flush; state only affects the error flag.
  always_comb begin
    ctrl.PC_en       = 1'b1;
    ctrl.IFID_en     = 1'b1;
    ctrl.IFID_flush  = 1'b0;
    ctrl.IDEX_en     = 1'b1;
    ctrl.IDEX_bubble = 1'b0;
    ctrl.EXMEM_en    = 1'b1;
    ctrl.MEMWB_en    = 1'b1;
    hazard_timeout   = (state_q == ERR);
    if (freeze) begin
      ctrl.PC_en    = 1'b0;
      ctrl.IFID_en  = 1'b0;
      ctrl.IDEX_en  = 1'b0;
      ctrl.EXMEM_en = 1'b0;
      ctrl.MEMWB_en = 1'b0;
    end else if (hazard) begin
      ctrl.PC_en       = 1'b0;
      ctrl.IFID_en     = 1'b0;
      ctrl.IDEX_bubble = 1'b1;
    end else if (flush) begin
      ctrl.IFID_flush = 1'b1;
    end
  end

  // Redirect pending: captured during freeze, consumed by the first issued flush.
  always_comb begin
    redirect_pend_d = redirect_pend_q;
    if (freeze && ctrl.redirect)    redirect_pend_d = 1'b1;
    else if (!freeze && !hazard && flush) redirect_pend_d = 1'b0;
  end

  // Watchdog run length: clears without hazard, holds under freeze, saturates.
  always_comb begin
    haz_run_d = haz_run_q;
    if (!hazard)                            haz_run_d = '0;
    else if (!freeze && haz_run_q != HR_MAX) haz_run_d = haz_run_q + 1'b1;
  end

  // Redirect-pending and watchdog registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      redirect_pend_q <= 1'b0;
      haz_run_q       <= '0;
    end else begin
      redirect_pend_q <= redirect_pend_d;
      haz_run_q       <= haz_run_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_cnt_stall (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (haz_stall),
    .q     (cnt_stall)
  );

  sat_counter #(.W(CNT_W)) u_cnt_freeze (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (freeze),
    .q     (cnt_freeze)
  );

  sat_counter #(.W(CNT_W)) u_cnt_flush (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (ctrl.IFID_flush),
    .q     (cnt_flush)
  );

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed + randomized bench for pipeline_stall_ctrl against a rule-level model.
module tb_pipeline_stall_ctrl;

  localparam int unsigned STALL_MAX = 4;
  localparam int unsigned CNT_W     = 4;
  localparam int          CNT_MAX   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             hazard_timeout;
  logic [CNT_W-1:0] cnt_stall, cnt_freeze, cnt_flush;

  pipeline_stall_ctrl_if ctrl_if ();

  pipeline_stall_ctrl #(
    .STALL_MAX (STALL_MAX),
    .CNT_W     (CNT_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ctrl           (ctrl_if),
    .hazard_timeout (hazard_timeout),
    .cnt_stall      (cnt_stall),
    .cnt_freeze     (cnt_freeze),
    .cnt_flush      (cnt_flush)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit m_pend;
  int m_run;
  bit m_to;
  int m_cs, m_cf, m_cfl;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // {PC_en, IFID_en, IFID_flush, IDEX_en, IDEX_bubble, EXMEM_en, MEMWB_en}
  function automatic logic [6:0] exp_ctrl(input bit rst, sj, lu, ic, dc, rd);
    bit fr = ic | dc;
    bit hz = sj | lu;
    bit fl = rd | (m_pend & rst);
    if (fr)      return 7'b000_0000;
    else if (hz) return 7'b000_1111;
    else if (fl) return 7'b111_1011;
    else         return 7'b110_1011;
  endfunction

  function automatic int sat(input int v);
    return (v > CNT_MAX) ? CNT_MAX : v;
  endfunction

  // One clock: drive inputs, check combinational controls, clock, check state.
  task automatic cycle(input string tag, input bit rst, sj, lu, ic, dc, rd);
    logic [6:0] obs;
    bit fr, hz;
    rst_n                = rst;
    ctrl_if.stallJ       = sj;
    ctrl_if.load_use     = lu;
    ctrl_if.ICache_stall = ic;
    ctrl_if.DCache_stall = dc;
    ctrl_if.redirect     = rd;
    #2;
    obs = {ctrl_if.PC_en, ctrl_if.IFID_en, ctrl_if.IFID_flush, ctrl_if.IDEX_en,
           ctrl_if.IDEX_bubble, ctrl_if.EXMEM_en, ctrl_if.MEMWB_en};
    check({tag, "_ctrl"}, 32'(obs), 32'(exp_ctrl(rst, sj, lu, ic, dc, rd)));
    fr = ic | dc;
    hz = sj | lu;
    if (!rst) begin
      m_pend = 0; m_run = 0; m_to = 0; m_cs = 0; m_cf = 0; m_cfl = 0;
    end else begin
      if (fr)                  m_cf  = sat(m_cf + 1);
      else if (hz)             m_cs  = sat(m_cs + 1);
      else if (rd || m_pend)   m_cfl = sat(m_cfl + 1);
      if (fr && rd)            m_pend = 1;
      else if (!fr && !hz)     m_pend = 0;
      if (!hz)                 m_run = 0;
      else if (!fr)            m_run++;
      if (m_run >= STALL_MAX)  m_to = 1;
    end
    @(posedge clk);
    #1;
    check({tag, "_timeout"},    32'(hazard_timeout), 32'(m_to));
    check({tag, "_cnt_stall"},  32'(cnt_stall),      32'(m_cs));
    check({tag, "_cnt_freeze"}, 32'(cnt_freeze),     32'(m_cf));
    check({tag, "_cnt_flush"},  32'(cnt_flush),      32'(m_cfl));
  endtask

  task automatic idle(input string tag);
    cycle(tag, 1, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset(input string tag);
    cycle(tag, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst_n = 0;
    ctrl_if.stallJ = 0; ctrl_if.load_use = 0; ctrl_if.ICache_stall = 0;
    ctrl_if.DCache_stall = 0; ctrl_if.redirect = 0;
    m_pend = 0; m_run = 0; m_to = 0; m_cs = 0; m_cf = 0; m_cfl = 0;
    #1;

    // Reset and idle
    do_reset("rst0");
    do_reset("rst1");
    check("rst_cnt_stall", 32'(cnt_stall), 0);
    check("rst_timeout", 32'(hazard_timeout), 0);
    idle("idle0");

    // One-cycle load-use
    cycle("lu", 1, 0, 1, 0, 0, 0);
    idle("lu_after");
    check("lu_cnt_stall", 32'(cnt_stall), 1);

    // I-cache miss for 5 cycles, redirect in cycle 2
    do_reset("rst_ic");
    cycle("ic1", 1, 0, 0, 1, 0, 0);
    cycle("ic2", 1, 0, 0, 1, 0, 1);
    cycle("ic3", 1, 0, 0, 1, 0, 0);
    cycle("ic4", 1, 0, 0, 1, 0, 0);
    cycle("ic5", 1, 0, 0, 1, 0, 0);
    check("ic_flush_pending", 32'(ctrl_if.IFID_flush), 0);
    idle("ic6");
    idle("ic7");
    check("ic_cnt_freeze", 32'(cnt_freeze), 5);
    check("ic_cnt_flush", 32'(cnt_flush), 1);

    // Watchdog: stallJ for STALL_MAX cycles
    do_reset("rst_wd");
    for (int i = 0; i < STALL_MAX; i++) cycle("wd_sj", 1, 1, 0, 0, 0, 0);
    check("wd_trip", 32'(hazard_timeout), 1);
    idle("wd_drop0");
    idle("wd_drop1");
    check("wd_sticky", 32'(hazard_timeout), 1);
    do_reset("wd_rst");
    check("wd_cleared", 32'(hazard_timeout), 0);

    // Hazard under D-cache freeze: watchdog run holds
    cycle("hf_pre", 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle("hf", 1, 1, 0, 0, 1, 0);
    check("hf_cnt_stall", 32'(cnt_stall), 1);
    cycle("hf_post0", 1, 1, 0, 0, 0, 0);
    cycle("hf_post1", 1, 1, 0, 0, 0, 0);
    cycle("hf_post2", 1, 1, 0, 0, 0, 0);
    check("hf_run_held", 32'(hazard_timeout), 1);

    // Freeze + hazard + redirect together
    do_reset("rst_all");
    cycle("all3", 1, 1, 1, 1, 1, 1);
    cycle("all3_haz", 1, 0, 1, 0, 0, 0);
    idle("all3_flush");
    check("all3_cnt_flush", 32'(cnt_flush), 1);

    // Flush counter saturation
    do_reset("rst_sat");
    for (int i = 0; i < 16; i++) cycle("sat_rd", 1, 0, 0, 0, 0, 1);
    check("sat_15", 32'(cnt_flush), 15);
    cycle("sat_hold", 1, 0, 0, 0, 0, 1);
    check("sat_hold15", 32'(cnt_flush), 15);

    // Reset mid-freeze with pending redirect
    cycle("rmf_fr", 1, 0, 0, 1, 0, 1);
    cycle("rmf_rst", 0, 0, 0, 1, 0, 0);
    idle("rmf_idle");
    check("rmf_no_flush", 32'(cnt_flush), 0);
    check("rmf_cnt_freeze", 32'(cnt_freeze), 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cycle("rnd",
            ($urandom_range(49) != 0),
            ($urandom_range(4) == 0),
            ($urandom_range(4) == 0),
            ($urandom_range(5) == 0),
            ($urandom_range(5) == 0),
            ($urandom_range(3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
